// File: rtl/keypad_entry_if.sv
// Result bus from the keypad reader to the display path: the BCD entry word
// and the accepted-key strobes.
interface keypad_entry_if;
  logic [15:0] number_data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        entry_done;

  modport master (output number_data, key_code, key_valid, entry_done);
  modport slave  (input  number_data, key_code, key_valid, entry_done);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: column drive, row sync, press/release debounce,
// key decode and shift-entry of four BCD digits.
module keypad_entry #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     row_in,
  output logic [3:0]     col_out,
  keypad_entry_if.master kif
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, ACCEPT, HELD} state_t;

  state_t           state, state_nxt;
  logic [1:0][3:0]  sync_pipe;
  logic [3:0]       rs;
  logic [1:0]       col, col_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       pat, pat_nxt;
  logic [1:0]       row_idx, row_idx_nxt, low_row;
  logic [15:0]      num_q, num_nxt;
  logic [3:0]       code_q, code_nxt, dec_code;
  logic             kv_q, kv_nxt, done_q, done_nxt;

  assign rs = sync_pipe[1];

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'd1;   4'h1: key_map = 4'd2;
      4'h2: key_map = 4'd3;   4'h3: key_map = 4'd10;
      4'h4: key_map = 4'd4;   4'h5: key_map = 4'd5;
      4'h6: key_map = 4'd6;   4'h7: key_map = 4'd11;
      4'h8: key_map = 4'd7;   4'h9: key_map = 4'd8;
      4'hA: key_map = 4'd9;   4'hB: key_map = 4'd12;
      4'hC: key_map = 4'd14;  4'hD: key_map = 4'd0;
      4'hE: key_map = 4'd15;  default: key_map = 4'd13;
    endcase
  endfunction

  // Several rows low at once: the lowest-index row wins.
  always_comb begin
    if      (!rs[0]) low_row = 2'd0;
    else if (!rs[1]) low_row = 2'd1;
    else if (!rs[2]) low_row = 2'd2;
    else             low_row = 2'd3;
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    div_nxt     = div;
    cnt_nxt     = cnt;
    pat_nxt     = pat;
    row_idx_nxt = row_idx;
    num_nxt     = num_q;
    code_nxt    = code_q;
    kv_nxt      = 1'b0;
    done_nxt    = 1'b0;
    dec_code    = key_map(row_idx, col);
    case (state)
      SCAN: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (rs != 4'hF) begin
            pat_nxt     = rs;
            row_idx_nxt = low_row;
            cnt_nxt     = '0;
            state_nxt   = PRESS_DB;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      PRESS_DB: begin
        if (rs != pat) begin
          state_nxt = SCAN;
          col_nxt   = col + 2'd1;
          div_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          // Outputs are loaded on entry so they are visible during ACCEPT.
          state_nxt = ACCEPT;
          kv_nxt    = 1'b1;
          code_nxt  = dec_code;
          if (dec_code <= 4'd9)       num_nxt  = {num_q[11:0], dec_code};
          else if (dec_code == 4'd14) num_nxt  = 16'h0000;
          else if (dec_code == 4'd15) done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ACCEPT: begin
        state_nxt = HELD;
        cnt_nxt   = '0;
      end
      default: begin
        if (rs != 4'hF) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = SCAN;
          div_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pipe <= '1;
      state     <= SCAN;
      col       <= 2'd0;
      col_out   <= 4'b1110;
      div       <= '0;
      cnt       <= '0;
      pat       <= 4'hF;
      row_idx   <= 2'd0;
      num_q     <= 16'h0000;
      code_q    <= 4'h0;
      kv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], row_in};
      state     <= state_nxt;
      col       <= col_nxt;
      col_out   <= ~(4'b0001 << col_nxt);
      div       <= div_nxt;
      cnt       <= cnt_nxt;
      pat       <= pat_nxt;
      row_idx   <= row_idx_nxt;
      num_q     <= num_nxt;
      code_q    <= code_nxt;
      kv_q      <= kv_nxt;
      done_q    <= done_nxt;
    end
  end

  assign kif.number_data = num_q;
  assign kif.key_code    = code_q;
  assign kif.key_valid   = kv_q;
  assign kif.entry_done  = done_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a switch-matrix model driven by a table of
// key presses, plus hand sequences for bounce, hold, and reset corner cases.
module tb_keypad_entry;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] pressed = 16'h0;  // bit r*4+c closes switch row r / column c
  logic        gate = 1'b1;      // contact bounce: 0 opens every closed switch

  int checks = 0;
  int errors = 0;

  keypad_entry_if kif();

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .kif(kif)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~((|(pressed[r*4 +: 4] & ~col_out)) & gate);
  end

  typedef struct {
    logic [15:0] keys;
    int          hold;
    int          rel;
    logic [3:0]  code;
    logic [15:0] data;
    int          done;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a key set, then release; collect strobes seen over the whole window.
  task automatic apply(input logic [15:0] keys, input int hold, input int rel,
                       output int pulses, output logic [3:0] code,
                       output logic [15:0] data, output int dones);
    pulses = 0; dones = 0; code = 4'hX; data = 16'hXXXX;
    for (int i = 0; i < hold + rel; i++) begin
      pressed = (i < hold) ? keys : 16'h0;
      tick();
      if (kif.key_valid) begin
        pulses++;
        code = kif.key_code;
        data = kif.number_data;
      end
      if (kif.entry_done) dones++;
    end
  endtask

  task automatic chk_vec(input string name, input vec_t v);
    int p, d;
    logic [3:0] c;
    logic [15:0] n;
    apply(v.keys, v.hold, v.rel, p, c, n, d);
    chk({name, " pulses"}, p, 1);
    chk({name, " key_code"}, {28'h0, c}, {28'h0, v.code});
    chk({name, " number_data"}, {16'h0, n}, {16'h0, v.data});
    chk({name, " entry_done"}, d, v.done);
  endtask

  initial begin
    int p, d, run;
    logic [3:0] c;
    logic [15:0] n;
    bit found;

    //            keys      hold rel code   data      done
    vecs[0]  = '{16'h0001, 30, 30, 4'd1,  16'h0001, 0};  // 1
    vecs[1]  = '{16'h0002, 30, 30, 4'd2,  16'h0012, 0};  // 2
    vecs[2]  = '{16'h0004, 30, 30, 4'd3,  16'h0123, 0};  // 3
    vecs[3]  = '{16'h0010, 30, 30, 4'd4,  16'h1234, 0};  // 4
    vecs[4]  = '{16'h0020, 30, 30, 4'd5,  16'h2345, 0};  // 5
    vecs[5]  = '{16'h1000, 30, 30, 4'd14, 16'h0000, 0};  // *
    vecs[6]  = '{16'h0001, 30, 30, 4'd1,  16'h0001, 0};
    vecs[7]  = '{16'h0002, 30, 30, 4'd2,  16'h0012, 0};
    vecs[8]  = '{16'h0004, 30, 30, 4'd3,  16'h0123, 0};
    vecs[9]  = '{16'h0010, 30, 30, 4'd4,  16'h1234, 0};
    vecs[10] = '{16'h4000, 30, 30, 4'd15, 16'h1234, 1};  // #
    vecs[11] = '{16'h1000, 30, 30, 4'd14, 16'h0000, 0};  // *
    vecs[12] = '{16'h0008, 30, 30, 4'd10, 16'h0000, 0};  // A
    vecs[13] = '{16'h0080, 30, 30, 4'd11, 16'h0000, 0};  // B
    vecs[14] = '{16'h0800, 30, 30, 4'd12, 16'h0000, 0};  // C
    vecs[15] = '{16'h0400, 30, 30, 4'd9,  16'h0009, 0};  // 9
    vecs[16] = '{16'h2000, 30, 30, 4'd0,  16'h0090, 0};  // 0
    vecs[17] = '{16'h8000, 30, 30, 4'd13, 16'h0090, 0};  // D
    vecs[18] = '{16'h0200, 30, 30, 4'd8,  16'h0908, 0};  // 8

    // Reset and idle scan
    repeat (3) @(negedge clk);
    chk("reset col_out", {28'h0, col_out}, 32'he);
    chk("reset number_data", {16'h0, kif.number_data}, 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("idle col_out", {28'h0, col_out}, {28'h0, ~(4'b0001 << ((k / 4) % 4))});
      chk("idle key_valid", {31'h0, kif.key_valid}, 32'h0);
      tick();
    end
    chk("idle key_code", {28'h0, kif.key_code}, 32'h0);
    chk("idle entry_done", {31'h0, kif.entry_done}, 32'h0);

    for (int i = 0; i < 19; i++) chk_vec($sformatf("vec%0d", i), vecs[i]);

    // Bounce rejection on key 5 (r1c1), starting as column 1 is driven
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (col_out == 4'b1101) found = 1; else tick();
    end
    chk("bounce col1 found", {31'h0, found}, 32'h1);
    pressed = 16'h0020; gate = 1'b1; p = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0 && i != 0) gate = ~gate;
      tick();
      if (kif.key_valid) p++;
    end
    chk("bounce no accept", p, 0);
    gate = 1'b1;
    apply(16'h0020, 40, 30, p, c, n, d);
    chk("bounce stable pulses", p, 1);
    chk("bounce key_code", {28'h0, c}, 32'd5);
    chk("bounce number_data", {16'h0, n}, 32'h9085);

    // Long hold of 7: a single accept, no repeat
    apply(16'h0100, 200, 30, p, c, n, d);
    chk("hold pulses", p, 1);
    chk("hold key_code", {28'h0, c}, 32'd7);
    chk("hold number_data", {16'h0, n}, 32'h0857);

    // r0 and r2 together in column 0: row 0 wins
    apply(16'h0101, 30, 30, p, c, n, d);
    chk("simul pulses", p, 1);
    chk("simul key_code", {28'h0, c}, 32'd1);
    chk("simul number_data", {16'h0, n}, 32'h8571);

    // Reset while debouncing key 9 (r2c2): column 2 held past its dwell
    pressed = 16'h0400; run = 0; p = 0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (kif.key_valid) p++;
      run = (col_out == 4'b1011) ? run + 1 : 0;
      if (run == 6) found = 1;
    end
    chk("rstdb reached debounce", {31'h0, found}, 32'h1);
    chk("rstdb no early accept", p, 0);
    rst = 1'b0;
    #1;
    chk("rstdb col_out", {28'h0, col_out}, 32'he);
    chk("rstdb number_data", {16'h0, kif.number_data}, 32'h0);
    chk("rstdb key_code", {28'h0, kif.key_code}, 32'h0);
    chk("rstdb key_valid", {31'h0, kif.key_valid}, 32'h0);
    chk("rstdb entry_done", {31'h0, kif.entry_done}, 32'h0);
    tick();
    rst = 1'b1;
    apply(16'h0400, 40, 30, p, c, n, d);
    chk("rstdb pulses", p, 1);
    chk("rstdb key_code after", {28'h0, c}, 32'd9);
    chk("rstdb number_data after", {16'h0, n}, 32'h0009);
    chk("rstdb entry_done after", d, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Scanned 4x4 matrix-keypad reader that produces the 16-bit, four-digit BCD `number_data` word consumed by the seven-segment display path. The display path drives scan lines outward; this block is the input end. It drives keypad columns, samples rows, debounces presses and releases, and decodes each key. Digit keys are accumulated into a shift-entry BCD register, with clear and enter keys.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven before rows are sampled; must be ≥ 4.
- `DEBOUNCE_CNT`, default 500000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad rows, active-low (pulled up externally); asynchronous to `clk`.
- `col_out`  out  4  column drive, one-hot active-low; `col_out[c]`=0 selects column c.
- `number_data`  out  16  BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- `key_code`  out  4  code of the last accepted key.
- `key_valid`  out  1  one-cycle pulse when a key is accepted.
- `entry_done`  out  1  one-cycle pulse when the enter key is accepted.

## Operation
- **Row synchronizer.** `row_in` passes through a 2-flop synchronizer. All logic uses the synchronized value `rs`.
- **Key map.** Row r, column c maps to the following codes:
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14 (`*`), 0, 15 (`#`), 13
- **Multiple rows low.** The lowest-index low row wins.
- **SCAN state.**
  - Drive the current column low and run the divider 0..`SCAN_DIV`-1.
  - On terminal count with `rs`≠4'hF: latch the column, the row pattern and the row index, clear the debounce counter, and go to PRESS_DB. The column stays driven.
  - Otherwise advance to the next column, with wrap 3→0.
- **PRESS_DB state.**
  - Each cycle in which `rs` equals the latched pattern increments the counter.
  - Any mismatch returns to SCAN at the next column.
  - When the counter reaches `DEBOUNCE_CNT`-1, go to ACCEPT.
- **ACCEPT state** (1 cycle).
  - Register `key_code` and pulse `key_valid`.
  - Apply the key action, then go to HELD.
- **HELD state.**
  - The latched column stays driven and the counter resets.
  - Count consecutive cycles with `rs`=4'hF. Any low row clears the counter.
  - When the counter reaches `DEBOUNCE_CNT`-1, return to SCAN with the same column and a cleared divider.
  - A held key produces exactly one `key_valid`; there is no auto-repeat.
- **Key actions** (all applied in ACCEPT):
  - Digit 0–9: `number_data` ← {`number_data`[11:0], digit}. The thousands digit is discarded.
  - Code 14: `number_data` ← 16'h0000.
  - Code 15: pulse `entry_done`; `number_data` is unchanged.
  - Codes 10–13: only `key_valid`/`key_code`; `number_data` is unchanged.
- **Digit validity.** Every nibble of `number_data` is always in the range 0–9.

## Timing
- **Reset values** (asynchronous): state SCAN, column 0, `col_out`=4'b1110, divider and counter 0, synchronizer flops 4'hF, `number_data`=16'h0000, `key_code`=4'h0, `key_valid`=0, `entry_done`=0.
- **Output registration.** All outputs are registered. `key_valid`, `entry_done`, `key_code` and the updated `number_data` all appear in the same cycle.
- **Press latency.**
  - Row samples are taken at divider terminal count.
  - Accept occurs `DEBOUNCE_CNT`+1 cycles after the sample cycle.
  - The synchronizer adds 2 cycles from the pin.
- **Column dwell.** Each column is driven for exactly `SCAN_DIV` cycles while no key is pressed. A full sweep takes 4×`SCAN_DIV` cycles.
- **Minimum spacing.** `key_valid` pulses are separated by at least 2×`DEBOUNCE_CNT` cycles.
- **Reset mid-operation.** Reset asserted in any state aborts immediately. Pulses deassert and any partial debounce is lost.
- **Key change during HELD.** A different key pressed while in HELD only delays release detection. It is never accepted until a full release has been observed.

## Test plan
Test parameters: `SCAN_DIV`=4, `DEBOUNCE_CNT`=8.

- **Reset and idle scan.** Assert reset, then release with rows=4'hF → `col_out` cycles 1110→1101→1011→0111→1110, 4 clocks each. All outputs hold their reset values.
- **Digit entry.** Press keys 1, 2, 3, 4 in sequence (r0c0, r0c1, r0c2, r1c0), each held 30 cycles then released 30 cycles.
  - Expect 4 `key_valid` pulses.
  - `number_data` reads 0x0001, 0x0012, 0x0123, 0x1234.
  - Pressing 5 next gives 0x2345.
- **Clear and enter.** With `number_data`=0x1234:
  - Press `#` (r3c2) → `entry_done` for 1 cycle, `key_code`=15, data unchanged.
  - Press `*` (r3c0) → data 0x0000, `entry_done` stays 0.
- **Bounce rejection.** Row 1 goes low at the column-1 sample, then toggles high/low every 3 cycles for 40 cycles → no `key_valid`. When it then holds stable, exactly one accept occurs with `key_code`=5.
- **Hold without repeat, plus simultaneous keys.**
  - Hold key 7 for 200 cycles → a single `key_valid`.
  - Press r0 and r2 together in column 0 → `key_code`=1 (lowest row wins).
  - Press A (r0c3) → `key_valid` with `key_code`=10, data unchanged.
- **Reset during PRESS_DB.** Assert reset while in PRESS_DB → all outputs return to reset values within the reset cycle. After release, the held key is accepted once via a fresh scan.
